// File: rtl/fp8_fixed_decoder_pkg.sv
// Shared FP8 definitions for fp8_pkg: field layout, class and decoder state enums, default widths.
// Imported by fp8_classify and fp8_fixed_decoder.
package fp8_pkg;

    localparam int SIGN_BIT = 7;
    localparam int EXP_W    = 4;
    localparam int MAN_W    = 3;

    localparam logic [EXP_W-1:0] EXP_SPECIAL = 4'hF;

    localparam int OUT_W_DEF  = 20;
    localparam int FRAC_W_DEF = 10;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp8_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_SIGN,
        ST_HOLD
    } dec_state_e;

endpackage

// File: rtl/fp8_fixed_decoder_classify.sv
// fp8_classify: splits an FP8 word into class, sign, exponent and 4-bit significand.
// Purely combinational; no subnormals, so exp=0 with mant!=0 still carries the hidden one.
module fp8_classify
    import fp8_pkg::*;
(
    input  logic [7:0]       in_data,
    output fp8_class_e       cls,
    output logic             sign,
    output logic [EXP_W-1:0] exp_f,
    output logic [MAN_W:0]   mant_full
);

    logic [MAN_W-1:0] mant;

    always_comb begin
        sign      = in_data[SIGN_BIT];
        exp_f     = in_data[SIGN_BIT-1:MAN_W];
        mant      = in_data[MAN_W-1:0];
        mant_full = {1'b1, mant};
        cls       = CLS_NORM;
        if (exp_f == EXP_SPECIAL) begin
            cls = (mant == '0) ? CLS_INF : CLS_NAN;
        end else if (exp_f == '0 && mant == '0) begin
            cls = CLS_ZERO;
        end
    end

endmodule

// File: rtl/fp8_fixed_decoder.sv
// fp8_fixed_decoder: FP8 to signed Q-format converter using a one-bit-per-cycle shifter.
// Optional status flags (flag_zero/flag_inf/flag_nan) are built when FP8_DEC_FLAGS_EN is defined.
module fp8_fixed_decoder
    import fp8_pkg::*;
#(
    parameter int OUT_W  = OUT_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output dec_state_e       dbg_state
`ifdef FP8_DEC_FLAGS_EN
    ,
    output logic             flag_zero,
    output logic             flag_inf,
    output logic             flag_nan
`endif
);

    // Handshake: a transfer happens on a clock edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in HOLD, so the two never overlap.

    // Significand weight: 1.mmm * 2^(exp-bias) scaled by 2^FRAC_W is M << (exp + LOAD_SHIFT).
    localparam int BIAS       = (2 ** (EXP_W - 1)) - 1;
    localparam int LOAD_SHIFT = FRAC_W - BIAS - MAN_W;

    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    fp8_class_e       cls;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [MAN_W:0]   in_mant;

    dec_state_e       state;
    logic [EXP_W-1:0] cnt;
    logic [OUT_W-1:0] mag;
    logic             sgn;

    fp8_classify u_classify (
        .in_data   (in_data),
        .cls       (cls),
        .sign      (in_sign),
        .exp_f     (in_exp),
        .mant_full (in_mant)
    );

    assign in_ready  = (state == ST_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n || !ena) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mag       <= '0;
            sgn       <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef FP8_DEC_FLAGS_EN
            flag_zero <= 1'b0;
            flag_inf  <= 1'b0;
            flag_nan  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        case (cls)
                            CLS_NORM: begin
                                mag   <= OUT_W'(in_mant) << LOAD_SHIFT;
                                cnt   <= in_exp;
                                sgn   <= in_sign;
                                state <= ST_SHIFT;
                            end
                            CLS_INF: begin
                                out_data  <= in_sign ? SAT_NEG : SAT_POS;
                                out_valid <= 1'b1;
                                state     <= ST_HOLD;
`ifdef FP8_DEC_FLAGS_EN
                                flag_inf  <= 1'b1;
`endif
                            end
                            default: begin
                                // Zero and NaN both decode to 0; their sign is dropped.
                                out_data  <= '0;
                                out_valid <= 1'b1;
                                state     <= ST_HOLD;
`ifdef FP8_DEC_FLAGS_EN
                                flag_zero <= (cls == CLS_ZERO);
                                flag_nan  <= (cls == CLS_NAN);
`endif
                            end
                        endcase
                    end
                end
                ST_SHIFT: begin
                    if (cnt != '0) begin
                        mag <= mag << 1;
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_SIGN;
                    end
                end
                ST_SIGN: begin
                    out_data  <= sgn ? -mag : mag;
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
`ifdef FP8_DEC_FLAGS_EN
                    flag_zero <= (mag == '0);
`endif
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
`ifdef FP8_DEC_FLAGS_EN
                        flag_zero <= 1'b0;
                        flag_inf  <= 1'b0;
                        flag_nan  <= 1'b0;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp8_fixed_decoder.sv
// Bench for fp8_fixed_decoder: vector table, random normals against an arithmetic model,
// and hand-written backpressure, abort and reset-priority sequences.
module tb_fp8_fixed_decoder;
    import fp8_pkg::*;

    localparam int OUT_W = 20;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    dec_state_e       dbg_state;
`ifdef FP8_DEC_FLAGS_EN
    logic             flag_zero;
    logic             flag_inf;
    logic             flag_nan;
`endif

    fp8_fixed_decoder #(.OUT_W(OUT_W), .FRAC_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dbg_state (dbg_state)
`ifdef FP8_DEC_FLAGS_EN
        ,
        .flag_zero (flag_zero),
        .flag_inf  (flag_inf),
        .flag_nan  (flag_nan)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard queues
    logic [OUT_W-1:0] exp_q[$];
    int               lat_q[$];
    logic [2:0]       flg_q[$];

    typedef struct {
        logic [7:0]       din;
        logic [OUT_W-1:0] dout;
        int               lat;
        logic [2:0]       flg;   // {zero, inf, nan}
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model built from the numeric definition of the format.
    task automatic model(input logic [7:0] d, output logic [OUT_W-1:0] v, output int lat,
                         output logic [2:0] flg);
        int e, m, mg;
        e = int'(d[6:3]);
        m = int'(d[2:0]);
        flg = 3'b000;
        if (e == 15) begin
            lat = 1;
            if (m == 0) begin
                v = d[7] ? 20'h80000 : 20'h7FFFF;
                flg = 3'b010;
            end else begin
                v = '0;
                flg = 3'b001;
            end
        end else if (e == 0 && m == 0) begin
            lat = 1;
            v = '0;
            flg = 3'b100;
        end else begin
            mg  = (8 + m) * (1 << e);
            v   = d[7] ? OUT_W'(-mg) : OUT_W'(mg);
            lat = e + 3;
        end
    endtask

    task automatic accept(input logic [7:0] d, output bit ok);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        ok = in_ready;
        if (!ok) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic push(input logic [7:0] d);
        logic [OUT_W-1:0] v;
        int               lat;
        logic [2:0]       flg;
        model(d, v, lat, flg);
        exp_q.push_back(v);
        lat_q.push_back(lat);
        flg_q.push_back(flg);
    endtask

    task automatic push_vec(input vec_t v);
        exp_q.push_back(v.dout);
        lat_q.push_back(v.lat);
        flg_q.push_back(v.flg);
    endtask

    // Called right after the accept edge; waits for out_valid and checks against the queue.
    task automatic wait_valid(input string name, input bit toggle);
        int cycles = 1;
        logic [OUT_W-1:0] e_d;
        int               e_l;
        logic [2:0]       e_f;
        while (!out_valid && cycles < 40) begin
            if (toggle) in_data = 8'($urandom);
            tick();
            cycles++;
        end
        e_d = exp_q.pop_front();
        e_l = lat_q.pop_front();
        e_f = flg_q.pop_front();
        check({name, "_latency"}, 32'(cycles), 32'(e_l));
        check({name, "_data"}, 32'(out_data), 32'(e_d));
        check({name, "_in_ready_low"}, 32'(in_ready), 32'd0);
`ifdef FP8_DEC_FLAGS_EN
        check({name, "_flags"}, 32'({flag_zero, flag_inf, flag_nan}), 32'(e_f));
`else
        if (e_f === 3'bxxx) check({name, "_flags_x"}, 32'(e_f), 32'd0);
`endif
    endtask

    task automatic release_out(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
`ifdef FP8_DEC_FLAGS_EN
        check({name, "_flags_clear"}, 32'({flag_zero, flag_inf, flag_nan}), 32'd0);
`endif
    endtask

    task automatic send(input string name, input logic [7:0] d);
        bit ok;
        push(d);
        accept(d, ok);
        if (ok) begin
            wait_valid(name, 1'b0);
            release_out(name);
        end else begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            void'(flg_q.pop_front());
        end
    endtask

    initial begin
        bit ok;
        logic [OUT_W-1:0] held;

        vecs[0]  = '{8'h38, 20'h00400, 10, 3'b000};
        vecs[1]  = '{8'hC4, 20'hFF400, 11, 3'b000};
        vecs[2]  = '{8'h01, 20'h00009,  3, 3'b000};
        vecs[3]  = '{8'h77, 20'h3C000, 17, 3'b000};
        vecs[4]  = '{8'hF7, 20'hC4000, 17, 3'b000};
        vecs[5]  = '{8'h00, 20'h00000,  1, 3'b100};
        vecs[6]  = '{8'h78, 20'h7FFFF,  1, 3'b010};
        vecs[7]  = '{8'hF8, 20'h80000,  1, 3'b010};
        vecs[8]  = '{8'h79, 20'h00000,  1, 3'b001};
        vecs[9]  = '{8'h80, 20'h00000,  1, 3'b100};
        vecs[10] = '{8'hF9, 20'h00000,  1, 3'b001};

        rst_n     = 1'b0;
        ena       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick();
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            push_vec(vecs[i]);
            accept(vecs[i].din, ok);
            if (ok) begin
                wait_valid($sformatf("vec%0d", i), 1'b0);
                check($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(ST_HOLD));
                release_out($sformatf("vec%0d", i));
            end
        end

        for (int i = 0; i < 20; i++) begin
            send($sformatf("rand%0d", i), 8'($urandom_range(0, 255)));
        end

        // Backpressure with in_data toggling during the shift.
        push(8'h40);
        accept(8'h40, ok);
        if (ok) begin
            wait_valid("bp", 1'b1);
            held = out_data;
            for (int i = 0; i < 5; i++) begin
                tick();
                check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
                check($sformatf("bp_hold_data%0d", i), 32'(out_data), 32'(held));
                check($sformatf("bp_hold_ready%0d", i), 32'(in_ready), 32'd0);
            end
            release_out("bp");
        end

        // Abort mid-shift via rst_n, then via ena.
        for (int k = 0; k < 2; k++) begin
            accept(8'h70, ok);
            repeat (4) tick();
            if (k == 0) rst_n = 1'b0; else ena = 1'b0;
            tick();
            check($sformatf("abort%0d_valid", k), 32'(out_valid), 32'd0);
            check($sformatf("abort%0d_in_ready", k), 32'(in_ready), 32'd1);
            check($sformatf("abort%0d_data", k), 32'(out_data), 32'd0);
            rst_n = 1'b1;
            ena   = 1'b1;
            send($sformatf("after_abort%0d", k), 8'h38);
        end

        // Reset in HOLD wins over a simultaneous out_ready: out_data must clear.
        push(8'h78);
        accept(8'h78, ok);
        if (ok) begin
            wait_valid("hold_rst", 1'b0);
            out_ready = 1'b1;
            rst_n     = 1'b0;
            tick();
            out_ready = 1'b0;
            rst_n     = 1'b1;
            check("hold_rst_valid", 32'(out_valid), 32'd0);
            check("hold_rst_data", 32'(out_data), 32'd0);
            check("hold_rst_in_ready", 32'(in_ready), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
